// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t   : controller states (IDLE, SHIFT, DONE)
//   WIDTH_DEF : default operand/result width
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Single-bit full adder, purely combinational.
// Ports:
//   a, b, ci : addend bits and carry-in
//   s        : sum bit  (a ^ b ^ ci)
//   c        : carry out (majority of a, b, ci)
module fa_bit
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ ci;
  assign c = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes {cout,sum} = a + b + ci one bit per clock,
// LSB first, through a single shared full-adder cell.
// A start in IDLE captures the operands; WIDTH SHIFT cycles follow, then
// one DONE cycle in which valid pulses. sum/cout (and ovf) only change on
// completion, so partial sums never appear on the outputs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an addition (ignored while busy)
//   a, b, ci   : operands and carry-in, sampled when start is accepted
//   busy       : high whenever the controller is not IDLE
//   valid      : one-cycle pulse with a new result
//   sum, cout  : last completed result
//   ovf        : signed overflow of the last result (only when the macro
//                SERIAL_ADDER_OVF_EN is defined)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  // Holds the WIDTH-1 result bits gathered so far; the final bit comes
  // straight from the adder on the last SHIFT edge.
  logic [WIDTH-2:0]   r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_next;
  logic               w_last;

  fa_bit u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .c  (w_c)
  );

  // New sum bit enters from the MSB side so that after WIDTH shifts
  // bit 0 of the operands lands in bit 0 of the result.
  assign w_next = {w_s, r_acc};
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ci;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          r_acc   <= w_next[WIDTH-1:1];
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            sum     <= w_next;
            cout    <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
            // r_carry here is the carry into the MSB.
            ovf     <= r_carry ^ w_c;
`endif
            valid   <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          valid   <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          valid   <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
